// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding / interlock unit.
//   - Default widths and depth used as parameter defaults by fwd_track_pipe
//     and fwd_src_lookup.
//   - Stage names indexing the post-ID tracker entries (0 = EX ... DEPTH-1 = WB).
package fwd_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_AW_DEF  = 5;
    localparam int DEPTH_DEF   = 3;
    localparam int NUM_SRC_DEF = 2;
    localparam int CNT_W_DEF   = 16;

    // Tracker entry index of each named stage (default three-stage pipe).
    localparam int ST_EX  = 0;
    localparam int ST_MEM = 1;
    localparam int ST_WB  = 2;

endpackage

// File: rtl/fwd_src_lookup.sv
// Resolves one ID-stage source operand against all tracked entries.
// Ports:
//   src          source register index
//   rf_data      register-file read data for this source
//   e_vld/e_we   per-entry valid / writes-register flags
//   e_rd         per-entry destination index
//   e_rdy/e_data per-entry captured-result flag and data
//   stg_res_vld  per-stage result valid this cycle (same-cycle bypass)
//   stg_res      per-stage result data
//   data         resolved operand value
//   hit          operand comes from the tracker, not the register file
//   unavail      youngest producer exists but its result is not yet known
module fwd_src_lookup
    import fwd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic [REG_AW-1:0]             src,
    input  logic [DATA_W-1:0]             rf_data,
    input  logic [DEPTH-1:0]              e_vld,
    input  logic [DEPTH-1:0]              e_we,
    input  logic [DEPTH-1:0][REG_AW-1:0]  e_rd,
    input  logic [DEPTH-1:0]              e_rdy,
    input  logic [DEPTH-1:0][DATA_W-1:0]  e_data,
    input  logic [DEPTH-1:0]              stg_res_vld,
    input  logic [DEPTH-1:0][DATA_W-1:0]  stg_res,
    output logic [DATA_W-1:0]             data,
    output logic                          hit,
    output logic                          unavail
);

    // NOTE: every output gets a default before the loop, so no path through
    // this block leaves a value held over -- that is what keeps it latch-free.
    always_comb begin
        data    = rf_data;
        hit     = 1'b0;
        unavail = 1'b0;
        // Walk oldest to youngest: the youngest match is the last one written,
        // so an older producer can never override it, ready or not.
        for (int s = DEPTH - 1; s >= 0; s--) begin
            if (e_vld[s] && e_we[s] && (e_rd[s] == src) && (e_rd[s] != '0)) begin
                hit = 1'b1;
                if (e_rdy[s]) begin
                    data    = e_data[s];
                    unavail = 1'b0;
                end else if (stg_res_vld[s]) begin
                    data    = stg_res[s];
                    unavail = 1'b0;
                end else begin
                    data    = rf_data;
                    unavail = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_track_pipe.sv
// Forwarding / interlock unit: tracks in-flight destination registers across
// DEPTH post-ID stages, captures their results, forwards the youngest producer
// to each ID source operand and stalls ID when that result is not yet known.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   id_vld/id_we/id_rd/id_flush   ID instruction, its destination, kill
//   pipe_hold     external freeze: entries do not shift, results still captured
//   id_src/id_src_use/rf_data     per-source index, used flag, RF read data
//   stg_res_vld/stg_res           per-stage result valid and data
//   fwd_data/fwd_sel_hit          resolved operands and tracker-hit flags
//   stall         hold IF/ID, bubble into EX
//   issue         ID instruction enters entry 0 on this edge
//   stall_cnt     saturating count of non-held stall cycles
module fwd_track_pipe
    import fwd_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_AW  = REG_AW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        id_vld,
    input  logic                        id_we,
    input  logic [REG_AW-1:0]           id_rd,
    input  logic                        id_flush,
    input  logic                        pipe_hold,
    input  logic [NUM_SRC*REG_AW-1:0]   id_src,
    input  logic [NUM_SRC-1:0]          id_src_use,
    input  logic [NUM_SRC*DATA_W-1:0]   rf_data,
    input  logic [DEPTH-1:0]            stg_res_vld,
    input  logic [DEPTH*DATA_W-1:0]     stg_res,
    output logic [NUM_SRC*DATA_W-1:0]   fwd_data,
    output logic [NUM_SRC-1:0]          fwd_sel_hit,
    output logic                        stall,
    output logic                        issue,
    output logic [CNT_W-1:0]            stall_cnt
);

    logic [DEPTH-1:0]              e_vld;
    logic [DEPTH-1:0]              e_we;
    logic [DEPTH-1:0][REG_AW-1:0]  e_rd;
    logic [DEPTH-1:0]              e_rdy;
    logic [DEPTH-1:0][DATA_W-1:0]  e_data;
    logic [DEPTH-1:0][DATA_W-1:0]  res_arr;
    logic [NUM_SRC-1:0]            unavail;

    assign res_arr = stg_res;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_lookup #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH)
        ) u_lookup (
            .src         (id_src[i*REG_AW +: REG_AW]),
            .rf_data     (rf_data[i*DATA_W +: DATA_W]),
            .e_vld       (e_vld),
            .e_we        (e_we),
            .e_rd        (e_rd),
            .e_rdy       (e_rdy),
            .e_data      (e_data),
            .stg_res_vld (stg_res_vld),
            .stg_res     (res_arr),
            .data        (fwd_data[i*DATA_W +: DATA_W]),
            .hit         (fwd_sel_hit[i]),
            .unavail     (unavail[i])
        );
    end

    // Only sources actually read can stall; a flushed ID never stalls.
    assign stall = id_vld & ~id_flush & (|(id_src_use & unavail));
    assign issue = id_vld & ~id_flush & ~stall & ~pipe_hold;

    // NOTE: state is updated with non-blocking assignments so every entry
    // shifts from the values it held before the edge, not from its neighbour's
    // freshly written value.
    // NOTE: the tracker is a handful of flops, not a RAM, so resetting data as
    // well as the flags costs nothing and keeps it free of X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_vld  <= '0;
            e_we   <= '0;
            e_rd   <= '0;
            e_rdy  <= '0;
            e_data <= '0;
        end else if (pipe_hold) begin
            // Frozen pipe: results still land in their own entry.
            for (int s = 0; s < DEPTH; s++) begin
                if (stg_res_vld[s]) begin
                    e_rdy[s]  <= 1'b1;
                    e_data[s] <= res_arr[s];
                end
            end
        end else begin
            e_vld[ST_EX]  <= issue;
            e_we[ST_EX]   <= issue & id_we;
            e_rd[ST_EX]   <= issue ? id_rd : '0;
            e_rdy[ST_EX]  <= 1'b0;
            e_data[ST_EX] <= '0;
            // Result produced in stage s travels with its instruction into s+1.
            for (int s = 0; s < DEPTH - 1; s++) begin
                e_vld[s+1]  <= e_vld[s];
                e_we[s+1]   <= e_we[s];
                e_rd[s+1]   <= e_rd[s];
                e_rdy[s+1]  <= e_rdy[s] | stg_res_vld[s];
                e_data[s+1] <= stg_res_vld[s] ? res_arr[s] : e_data[s];
            end
        end
    end

    // Held cycles are not counted: the pipe is frozen for another reason.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall && !pipe_hold && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_track_pipe.sv
// Scoreboard bench for fwd_track_pipe. The stimulus process drives one ID
// cycle at each falling edge, asks a queue-based reference model for the
// expected outputs and pushes them; a monitor pops and compares them against
// the DUT before the next rising edge.
module tb_fwd_track_pipe;

    localparam int DATA_W  = 32;
    localparam int REG_AW  = 5;
    localparam int DEPTH   = 3;
    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 4;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        id_vld = 1'b0;
    logic                        id_we = 1'b0;
    logic [REG_AW-1:0]           id_rd = '0;
    logic                        id_flush = 1'b0;
    logic                        pipe_hold = 1'b0;
    logic [NUM_SRC*REG_AW-1:0]   id_src = '0;
    logic [NUM_SRC-1:0]          id_src_use = '0;
    logic [NUM_SRC*DATA_W-1:0]   rf_data = '0;
    logic [DEPTH-1:0]            stg_res_vld = '0;
    logic [DEPTH*DATA_W-1:0]     stg_res = '0;
    logic [NUM_SRC*DATA_W-1:0]   fwd_data;
    logic [NUM_SRC-1:0]          fwd_sel_hit;
    logic                        stall;
    logic                        issue;
    logic [CNT_W-1:0]            stall_cnt;

    fwd_track_pipe #(
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW),
        .DEPTH   (DEPTH),
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_vld      (id_vld),
        .id_we       (id_we),
        .id_rd       (id_rd),
        .id_flush    (id_flush),
        .pipe_hold   (pipe_hold),
        .id_src      (id_src),
        .id_src_use  (id_src_use),
        .rf_data     (rf_data),
        .stg_res_vld (stg_res_vld),
        .stg_res     (stg_res),
        .fwd_data    (fwd_data),
        .fwd_sel_hit (fwd_sel_hit),
        .stall       (stall),
        .issue       (issue),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit                      rst;
        bit                      vld;
        bit                      we;
        bit                      flush;
        bit                      hold;
        bit [4:0]                rd;
        bit [1:0][4:0]           src;
        bit [1:0]                use_;
        bit [1:0][31:0]          rf;
        bit [2:0]                res_vld;
        bit [2:0][31:0]          res;
    } stim_t;

    typedef struct packed {
        bit                      vld;
        bit                      we;
        bit [4:0]                rd;
        bit                      rdy;
        bit [31:0]               data;
    } ins_t;

    typedef struct packed {
        bit                      stall;
        bit                      issue;
        bit [1:0]                hit;
        bit [1:0]                avail;
        bit [1:0][31:0]          data;
        bit [3:0]                cnt;
    } exp_t;

    // Reference model: index 0 of the queue is the youngest in-flight instruction.
    ins_t  pipe_q[$];
    int    m_cnt;
    exp_t  exp_q[$];
    stim_t cur_st;
    exp_t  cur_exp;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_clear();
        pipe_q.delete();
        for (int j = 0; j < DEPTH; j++) pipe_q.push_back('0);
        m_cnt = 0;
    endtask

    function automatic exp_t model_eval(input stim_t st);
        exp_t e;
        ins_t p;
        e     = '0;
        e.cnt = m_cnt[3:0];
        for (int i = 0; i < NUM_SRC; i++) begin
            e.data[i]  = st.rf[i];
            e.avail[i] = 1'b1;
            for (int j = 0; j < pipe_q.size(); j++) begin
                p = pipe_q[j];
                if (p.vld && p.we && p.rd == st.src[i] && p.rd != 0) begin
                    e.hit[i] = 1'b1;
                    if (p.rdy)                e.data[i]  = p.data;
                    else if (st.res_vld[j])   e.data[i]  = st.res[j];
                    else                      e.avail[i] = 1'b0;
                    break;
                end
            end
        end
        e.stall = st.vld && !st.flush && ((st.use_ & ~e.avail) != 2'b00);
        e.issue = st.vld && !st.flush && !e.stall && !st.hold;
        return e;
    endfunction

    task automatic model_step(input stim_t st, input exp_t e);
        ins_t p;
        if (st.rst) begin
            model_clear();
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                if (st.res_vld[j]) begin
                    p       = pipe_q[j];
                    p.rdy   = 1'b1;
                    p.data  = st.res[j];
                    pipe_q[j] = p;
                end
            end
            if (!st.hold) begin
                p = '0;
                if (e.issue) begin
                    p.vld = 1'b1;
                    p.we  = st.we;
                    p.rd  = st.rd;
                end
                pipe_q.push_front(p);
                void'(pipe_q.pop_back());
                if (e.stall && m_cnt < 15) m_cnt++;
            end
        end
    endtask

    task automatic drive(input stim_t st);
        @(negedge clk);
        rst         = st.rst;
        id_vld      = st.vld;
        id_we       = st.we;
        id_rd       = st.rd;
        id_flush    = st.flush;
        pipe_hold   = st.hold;
        id_src      = st.src;
        id_src_use  = st.use_;
        rf_data     = st.rf;
        stg_res_vld = st.res_vld;
        stg_res     = st.res;
        if (st.rst) model_clear();
        cur_st  = st;
        cur_exp = model_eval(st);
        exp_q.push_back(cur_exp);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(cur_st, cur_exp);
    endtask

    task automatic step(input stim_t st);
        drive(st);
        tick();
    endtask

    function automatic stim_t idle();
        stim_t s;
        s       = '0;
        s.rf[0] = $urandom;
        s.rf[1] = $urandom;
        return s;
    endfunction

    function automatic stim_t producer(input bit [4:0] rd);
        stim_t s;
        s     = idle();
        s.vld = 1'b1;
        s.we  = 1'b1;
        s.rd  = rd;
        return s;
    endfunction

    function automatic stim_t consumer(input bit [4:0] src0);
        stim_t s;
        s        = idle();
        s.vld    = 1'b1;
        s.src[0] = src0;
        s.use_   = 2'b01;
        return s;
    endfunction

    task automatic do_reset();
        stim_t s;
        s     = idle();
        s.rst = 1'b1;
        step(s);
        s     = consumer(5'd0);
        s.rst = 1'b1;
        drive(s);
        #2;
        check("rst_hit", 64'(fwd_sel_hit), 64'd0);
        check("rst_cnt", 64'(stall_cnt), 64'd0);
        tick();
    endtask

    // Monitor: compares every expectation pushed this cycle before the next rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall", 64'(stall), 64'(e.stall));
                check("issue", 64'(issue), 64'(e.issue));
                check("fwd_sel_hit", 64'(fwd_sel_hit), 64'(e.hit));
                check("stall_cnt", 64'(stall_cnt), 64'(e.cnt));
                for (int i = 0; i < NUM_SRC; i++) begin
                    if (e.avail[i])
                        check("fwd_data", 64'(fwd_data[i*DATA_W +: DATA_W]), 64'(e.data[i]));
                end
            end
        end
    end

    initial begin
        stim_t s;
        model_clear();

        // ALU chain: producer in EX bypassed with no stall.
        do_reset();
        step(producer(5'd3));
        s = consumer(5'd3);
        s.res_vld = 3'b001;
        s.res[0]  = 32'h11;
        drive(s);
        #2;
        check("alu_stall", 64'(stall), 64'd0);
        check("alu_data", 64'(fwd_data[31:0]), 64'h11);
        check("alu_hit", 64'(fwd_sel_hit[0]), 64'd1);
        tick();

        // Load-use: exactly one stall, then the loaded value is forwarded.
        do_reset();
        step(producer(5'd5));
        drive(consumer(5'd5));
        #2;
        check("lu_stall", 64'(stall), 64'd1);
        tick();
        s = consumer(5'd5);
        s.res_vld = 3'b010;
        s.res[1]  = 32'hAB;
        drive(s);
        #2;
        check("lu_stall2", 64'(stall), 64'd0);
        check("lu_data", 64'(fwd_data[31:0]), 64'hAB);
        tick();
        drive(idle());
        #2;
        check("lu_cnt", 64'(stall_cnt), 64'd1);
        tick();

        // Youngest wins over an older, ready producer of the same register.
        do_reset();
        step(producer(5'd7));
        s = producer(5'd1);
        s.res_vld = 3'b001;
        s.res[0]  = 32'h22;
        step(s);
        step(producer(5'd7));
        s = consumer(5'd7);
        s.hold = 1'b1;
        drive(s);
        #2;
        check("yw_stall", 64'(stall), 64'd1);
        tick();
        s = consumer(5'd7);
        s.res_vld = 3'b001;
        s.res[0]  = 32'h33;
        drive(s);
        #2;
        check("yw_data", 64'(fwd_data[31:0]), 64'h33);
        check("yw_stall2", 64'(stall), 64'd0);
        tick();

        // r0 never matches; an unready match on an unused source never stalls.
        do_reset();
        step(producer(5'd0));
        step(producer(5'd4));
        s = consumer(5'd0);
        s.src[1] = 5'd4;
        s.rf[0]  = 32'h1234;
        drive(s);
        #2;
        check("r0_hit", 64'(fwd_sel_hit[0]), 64'd0);
        check("r0_data", 64'(fwd_data[31:0]), 64'h1234);
        check("unused_stall", 64'(stall), 64'd0);
        tick();

        // pipe_hold: frozen entries still capture; held stalls are not counted.
        do_reset();
        step(producer(5'd6));
        step(idle());
        s = consumer(5'd6);
        s.hold = 1'b1;
        drive(s);
        #2;
        check("hold_stall", 64'(stall), 64'd1);
        tick();
        s.res_vld = 3'b010;
        s.res[1]  = 32'h5A;
        step(s);
        s.res_vld = 3'b000;
        step(s);
        drive(consumer(5'd6));
        #2;
        check("hold_data", 64'(fwd_data[31:0]), 64'h5A);
        check("hold_cnt", 64'(stall_cnt), 64'd0);
        tick();

        // Flush beats stall.
        do_reset();
        step(producer(5'd5));
        s = consumer(5'd5);
        s.flush = 1'b1;
        drive(s);
        #2;
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_issue", 64'(issue), 64'd0);
        tick();

        // Saturation: 21 stall cycles into a 4-bit counter.
        do_reset();
        repeat (7) begin
            step(producer(5'd5));
            repeat (3) step(consumer(5'd5));
        end
        drive(idle());
        #2;
        check("sat_cnt", 64'(stall_cnt), 64'hF);
        tick();

        // Reset mid-run discards everything in flight.
        step(producer(5'd9));
        s = consumer(5'd9);
        s.rst = 1'b1;
        drive(s);
        #2;
        check("mr_hit", 64'(fwd_sel_hit), 64'd0);
        check("mr_cnt", 64'(stall_cnt), 64'd0);
        tick();
        drive(consumer(5'd9));
        #2;
        check("post_rst_hit", 64'(fwd_sel_hit[0]), 64'd0);
        tick();

        // Random traffic on a small register set to provoke dependencies.
        for (int n = 0; n < 3000; n++) begin
            s         = idle();
            s.rst     = ($urandom_range(0, 199) == 0);
            s.vld     = ($urandom_range(0, 3) != 0);
            s.we      = ($urandom_range(0, 3) != 0);
            s.rd      = 5'($urandom_range(0, 7));
            s.flush   = ($urandom_range(0, 9) == 0);
            s.hold    = ($urandom_range(0, 7) == 0);
            s.src[0]  = 5'($urandom_range(0, 7));
            s.src[1]  = 5'($urandom_range(0, 7));
            s.use_    = 2'($urandom_range(0, 3));
            for (int j = 0; j < DEPTH; j++) begin
                s.res_vld[j] = ($urandom_range(0, 99) < 35);
                s.res[j]     = $urandom;
            end
            step(s);
        end

        @(negedge clk);
        #4;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
